// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester memory arbiter.
// Owner/state encodings plus the default-configuration request layout.
package mem_arb_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ERR  = 2'd2
   } state_e;

   // Address width for a given word count; never below one bit.
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEF_DEPTH  = 16;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_ADDR_W = addr_bits(DEF_DEPTH);

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_WIDTH-1:0]  wdata;
   } arb_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between IF and LS with a saturating starvation counter
// that hands IF the next arbitration after STARVE_LIMIT LS wins.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter  int STARVE_LIMIT = 4,
   localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en_i,
   input  logic if_valid_i,
   input  logic ls_valid_i,
   input  logic if_block_i,
   output logic if_grant_o,
   output logic ls_grant_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             starved;
   owner_e           winner;

   always_comb begin
      starved    = if_valid_i && (cnt_q == LIMIT);
      winner     = (if_valid_i && (!ls_valid_i || starved)) ? OWN_IF : OWN_LS;
      // A flushed IF winner blocks the whole slot; LS does not fall through.
      if_grant_o = arb_en_i && if_valid_i && (winner == OWN_IF) && !if_block_i;
      ls_grant_o = arb_en_i && ls_valid_i && (winner == OWN_LS);
      cnt_d      = cnt_q;
      if (!if_valid_i || if_grant_o) begin
         cnt_d = '0;
      end else if (ls_grant_o && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_ctrl port between instruction fetch and load/store,
// holding the access stable until mem_ready and routing the response back.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int DEPTH        = 16,
   parameter  int WIDTH        = 32,
   parameter  int STARVE_LIMIT = 4,
   localparam int ADDR_W       = addr_bits(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   input  logic              if_flush,
   output logic              if_resp_valid,
   output logic [WIDTH-1:0]  if_resp_data,
   output logic              if_resp_err,
   input  logic              ls_req_valid,
   input  logic              ls_req_we,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic [WIDTH-1:0]  ls_req_wdata,
   output logic              ls_req_ready,
   output logic              ls_resp_valid,
   output logic [WIDTH-1:0]  ls_resp_data,
   output logic              ls_resp_err,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [WIDTH-1:0]  mem_write_data,
   input  logic              mem_ready,
   input  logic [WIDTH-1:0]  mem_read_data
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  wdata;
   } req_t;

   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   req_t             req_q, req_d;
   logic             flush_pend_q, flush_pend_d;
   logic             if_resp_valid_q, if_resp_valid_d;
   logic             if_resp_err_q, if_resp_err_d;
   logic [WIDTH-1:0] if_resp_data_q, if_resp_data_d;
   logic             ls_resp_valid_q, ls_resp_valid_d;
   logic             ls_resp_err_q, ls_resp_err_d;
   logic [WIDTH-1:0] ls_resp_data_q, ls_resp_data_d;
   logic             arb_en, if_grant, ls_grant;
   logic             busy_rd, busy_wr;
   logic             if_drop;

   // Ready is combinational from state, so it must also be masked by rst.
   assign arb_en = (state_q == S_IDLE) && !rst;

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk       (clk),
      .rst       (rst),
      .arb_en_i  (arb_en),
      .if_valid_i(if_req_valid),
      .ls_valid_i(ls_req_valid),
      .if_block_i(if_flush),
      .if_grant_o(if_grant),
      .ls_grant_o(ls_grant)
   );

   assign if_req_ready = if_grant;
   assign ls_req_ready = ls_grant;

   // A flush arriving in the completion cycle still drops the response.
   assign if_drop = flush_pend_q || if_flush;

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      req_d           = req_q;
      flush_pend_d    = flush_pend_q;
      if_resp_valid_d = 1'b0;
      if_resp_err_d   = 1'b0;
      if_resp_data_d  = '0;
      ls_resp_valid_d = 1'b0;
      ls_resp_err_d   = 1'b0;
      ls_resp_data_d  = '0;
      case (state_q)
         S_IDLE: begin
            flush_pend_d = 1'b0;
            if (if_grant) begin
               owner_d    = OWN_IF;
               req_d.we    = 1'b0;
               req_d.addr  = if_req_addr;
               req_d.wdata = '0;
               state_d     = ({1'b0, if_req_addr} >= DEPTH_V) ? S_ERR : S_BUSY;
            end else if (ls_grant) begin
               owner_d     = OWN_LS;
               req_d.we    = ls_req_we;
               req_d.addr  = ls_req_addr;
               req_d.wdata = ls_req_wdata;
               state_d     = ({1'b0, ls_req_addr} >= DEPTH_V) ? S_ERR : S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               state_d      = S_IDLE;
               flush_pend_d = 1'b0;
               if (owner_q == OWN_IF) begin
                  if_resp_valid_d = !if_drop;
                  if_resp_data_d  = if_drop ? '0 : mem_read_data;
               end else begin
                  ls_resp_valid_d = 1'b1;
                  ls_resp_data_d  = req_q.we ? '0 : mem_read_data;
               end
            end else if ((owner_q == OWN_IF) && if_flush) begin
               flush_pend_d = 1'b1;
            end
         end
         S_ERR: begin
            state_d = S_IDLE;
            if (owner_q == OWN_IF) begin
               if_resp_valid_d = 1'b1;
               if_resp_err_d   = 1'b1;
            end else begin
               ls_resp_valid_d = 1'b1;
               ls_resp_err_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         owner_q         <= OWN_IF;
         req_q           <= '0;
         flush_pend_q    <= 1'b0;
         if_resp_valid_q <= 1'b0;
         if_resp_err_q   <= 1'b0;
         if_resp_data_q  <= '0;
         ls_resp_valid_q <= 1'b0;
         ls_resp_err_q   <= 1'b0;
         ls_resp_data_q  <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         req_q           <= req_d;
         flush_pend_q    <= flush_pend_d;
         if_resp_valid_q <= if_resp_valid_d;
         if_resp_err_q   <= if_resp_err_d;
         if_resp_data_q  <= if_resp_data_d;
         ls_resp_valid_q <= ls_resp_valid_d;
         ls_resp_err_q   <= ls_resp_err_d;
         ls_resp_data_q  <= ls_resp_data_d;
      end
   end

   // Access signals come straight from the held request, so they cannot
   // change while mem_ctrl is still working on them.
   assign busy_rd          = (state_q == S_BUSY) && !req_q.we;
   assign busy_wr          = (state_q == S_BUSY) && req_q.we;
   assign mem_read_enable  = busy_rd;
   assign mem_write_enable = busy_wr;
   assign mem_read_addr    = busy_rd ? req_q.addr : '0;
   assign mem_write_addr   = busy_wr ? req_q.addr : '0;
   assign mem_write_data   = busy_wr ? req_q.wdata : '0;

   assign if_resp_valid = if_resp_valid_q;
   assign if_resp_err   = if_resp_err_q;
   assign if_resp_data  = if_resp_data_q;
   assign ls_resp_valid = ls_resp_valid_q;
   assign ls_resp_err   = ls_resp_err_q;
   assign ls_resp_data  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable mem_ctrl responder plus a
// transaction-level reference (shadow memory, one outstanding access).
module tb_mem_arbiter;

   localparam int DEPTH  = 12;
   localparam int WIDTH  = 32;
   localparam int STARVE = 4;
   localparam int AW     = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             if_req_valid = 1'b0;
   logic [AW-1:0]    if_req_addr = '0;
   logic             if_req_ready;
   logic             if_flush = 1'b0;
   logic             if_resp_valid;
   logic [WIDTH-1:0] if_resp_data;
   logic             if_resp_err;
   logic             ls_req_valid = 1'b0;
   logic             ls_req_we = 1'b0;
   logic [AW-1:0]    ls_req_addr = '0;
   logic [WIDTH-1:0] ls_req_wdata = '0;
   logic             ls_req_ready;
   logic             ls_resp_valid;
   logic [WIDTH-1:0] ls_resp_data;
   logic             ls_resp_err;
   logic             mem_write_enable, mem_read_enable;
   logic [AW-1:0]    mem_write_addr, mem_read_addr;
   logic [WIDTH-1:0] mem_write_data;
   logic             mem_ready;
   logic [WIDTH-1:0] mem_read_data;

   mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .STARVE_LIMIT(STARVE)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .if_resp_err(if_resp_err),
      .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
      .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready), .ls_resp_valid(ls_resp_valid),
      .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
      .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
      .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
      .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return 32'hA500_0000 + 32'(i);
   endfunction

   // mem_ctrl responder: ready after mem_lat cycles of enable, then writes commit.
   logic [31:0] store [16];
   int          mem_cnt;
   int          mem_lat;
   int          lat_mode = 0;

   always @(posedge clk) begin
      if (rst) begin
         mem_cnt <= 0;
         mem_lat <= 0;
         for (int i = 0; i < 16; i++) store[i] <= init_word(i);
      end else if (mem_read_enable || mem_write_enable) begin
         if (mem_ready) begin
            mem_cnt <= 0;
            if (mem_write_enable) store[mem_write_addr] <= mem_write_data;
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt <= 0;
         mem_lat <= (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
      end
   end

   assign mem_ready     = (mem_read_enable || mem_write_enable) && (mem_cnt == mem_lat);
   assign mem_read_data = mem_ready ? store[mem_read_addr] : (32'hBAD0_0000 | 32'(mem_read_addr));

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference state: shadow memory and at most one access in flight.
   logic [31:0] shadow [16];
   int          cyc = 0;
   int          m_cnt = 0;
   int          m_free = 0;
   int          m_pulse = -1;
   logic        m_active = 1'b0, m_own_if = 1'b0, m_we = 1'b0, m_flushed = 1'b0;
   logic [3:0]  m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic        m_p_if = 1'b0, m_p_err = 1'b0, m_p_supp = 1'b0;
   logic [31:0] m_p_data = '0;

   // Observations used by directed checks.
   logic        if_fire = 1'b0, ls_fire = 1'b0;
   int          if_pulses = 0, ls_pulses = 0, rd_en_cycles = 0;
   int          last_if_cyc = 0, last_ls_cyc = 0, last_if_acc = 0, last_ls_acc = 0;
   logic [31:0] last_if_data = '0, last_ls_data = '0;
   logic        last_ls_err = 1'b0;
   byte         grant_log [$];

   task automatic model_step();
      logic e_if_v, e_ls_v, idle, win_if, e_if_rdy, e_ls_rdy;
      cyc++;
      if (if_resp_valid) begin
         if_pulses++; last_if_cyc = cyc; last_if_data = if_resp_data;
      end
      if (ls_resp_valid) begin
         ls_pulses++; last_ls_cyc = cyc; last_ls_data = ls_resp_data; last_ls_err = ls_resp_err;
      end
      if (mem_read_enable) rd_en_cycles++;
      if_fire = if_req_valid && if_req_ready;
      ls_fire = ls_req_valid && ls_req_ready;
      if (if_fire) last_if_acc = cyc;
      if (ls_fire) last_ls_acc = cyc;
      if (rst) begin
         m_active = 1'b0; m_free = 0; m_pulse = -1; m_cnt = 0; m_flushed = 1'b0;
         for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
         return;
      end
      e_if_v = (m_pulse == cyc) && m_p_if && !m_p_supp;
      e_ls_v = (m_pulse == cyc) && !m_p_if;
      check_eq("if_resp_valid", 32'(if_resp_valid), 32'(e_if_v));
      check_eq("ls_resp_valid", 32'(ls_resp_valid), 32'(e_ls_v));
      if (e_if_v) begin
         check_eq("if_resp_err", 32'(if_resp_err), 32'(m_p_err));
         check_eq("if_resp_data", if_resp_data, m_p_data);
      end
      if (e_ls_v) begin
         check_eq("ls_resp_err", 32'(ls_resp_err), 32'(m_p_err));
         check_eq("ls_resp_data", ls_resp_data, m_p_data);
      end
      check_eq("mem_read_enable", 32'(mem_read_enable), 32'(m_active && !m_we));
      check_eq("mem_write_enable", 32'(mem_write_enable), 32'(m_active && m_we));
      if (m_active && !m_we) check_eq("mem_read_addr", 32'(mem_read_addr), 32'(m_addr));
      if (m_active && m_we) begin
         check_eq("mem_write_addr", 32'(mem_write_addr), 32'(m_addr));
         check_eq("mem_write_data", mem_write_data, m_wdata);
      end
      if (m_active && mem_ready) begin
         if (m_we) shadow[m_addr] = m_wdata;
         m_pulse = cyc + 1; m_p_if = m_own_if; m_p_err = 1'b0;
         m_p_data = m_we ? 32'h0 : shadow[m_addr];
         m_p_supp = m_own_if && (m_flushed || if_flush);
         m_active = 1'b0; m_free = cyc + 1; m_flushed = 1'b0;
      end else if (m_active && m_own_if && if_flush) begin
         m_flushed = 1'b1;
      end
      idle     = !m_active && (cyc >= m_free);
      win_if   = if_req_valid && (!ls_req_valid || (m_cnt == STARVE));
      e_if_rdy = idle && win_if && !if_flush;
      e_ls_rdy = idle && ls_req_valid && !win_if;
      check_eq("if_req_ready", 32'(if_req_ready), 32'(e_if_rdy));
      check_eq("ls_req_ready", 32'(ls_req_ready), 32'(e_ls_rdy));
      if (!if_req_valid || e_if_rdy) m_cnt = 0;
      else if (e_ls_rdy && m_cnt < STARVE) m_cnt++;
      if (e_if_rdy || e_ls_rdy) begin
         grant_log.push_back(e_if_rdy ? 8'h49 : 8'h4C);
         m_own_if = e_if_rdy;
         m_we     = e_if_rdy ? 1'b0 : ls_req_we;
         m_addr   = e_if_rdy ? if_req_addr : ls_req_addr;
         m_wdata  = e_if_rdy ? 32'h0 : ls_req_wdata;
         if (int'(m_addr) >= DEPTH) begin
            m_pulse = cyc + 2; m_p_if = m_own_if; m_p_err = 1'b1; m_p_data = 32'h0;
            m_p_supp = 1'b0; m_free = cyc + 2;
         end else begin
            m_active = 1'b1; m_flushed = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) cycle();
   endtask

   task automatic ls_issue(input logic we, input logic [3:0] a, input logic [31:0] d);
      ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = a; ls_req_wdata = d;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (ls_fire) break;
      end
      check_eq("ls_accept", 32'(ls_fire), 32'd1);
      ls_req_valid = 1'b0;
   endtask

   task automatic if_issue(input logic [3:0] a);
      if_req_valid = 1'b1; if_req_addr = a;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (if_fire) break;
      end
      check_eq("if_accept", 32'(if_fire), 32'd1);
      if_req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    snap_if, snap_ls, snap_rd, start;
      string exp_seq;
      byte   g;

      // Reset: readies held low even with both requests valid.
      idle_cycles(2);
      if_req_valid = 1'b1; ls_req_valid = 1'b1;
      #2;
      check_eq("rst_if_ready", 32'(if_req_ready), 32'd0);
      check_eq("rst_ls_ready", 32'(ls_req_ready), 32'd0);
      check_eq("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'd0);
      check_eq("rst_resp_valid", 32'({if_resp_valid, ls_resp_valid}), 32'd0);
      check_eq("rst_ls_data", ls_resp_data, 32'd0);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      cycle();
      rst = 1'b0;
      idle_cycles(2);

      // LS write then read at zero latency.
      snap_if = if_pulses;
      ls_issue(1'b1, 4'd5, 32'hDEADBEEF);
      idle_cycles(3);
      check_eq("wr_ack_latency", 32'(last_ls_cyc - last_ls_acc), 32'd2);
      check_eq("wr_ack_data", last_ls_data, 32'd0);
      ls_issue(1'b0, 4'd5, 32'h0);
      idle_cycles(3);
      check_eq("rd_after_wr", last_ls_data, 32'hDEADBEEF);
      check_eq("no_if_pulse", 32'(if_pulses - snap_if), 32'd0);

      // Simultaneous requests: LS first, IF at the next idle.
      start = grant_log.size();
      if_req_valid = 1'b1; if_req_addr = 4'd3;
      ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 4'd7;
      for (int k = 0; k < 40 && (if_req_valid || ls_req_valid); k++) begin
         cycle();
         if (ls_fire) ls_req_valid = 1'b0;
         if (if_fire) if_req_valid = 1'b0;
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      idle_cycles(3);
      exp_seq = "LI";
      for (int i = 0; i < 2; i++) begin
         g = (start + i < grant_log.size()) ? grant_log[start + i] : 8'h3F;
         check_eq($sformatf("simul_grant%0d", i), 32'(g), 32'(exp_seq[i]));
      end

      // Both continuously valid: starvation limit forces every fifth grant to IF.
      start = grant_log.size();
      if_req_valid = 1'b1; if_req_addr = 4'd0;
      ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 4'd8; ls_req_wdata = $urandom;
      for (int k = 0; k < 300; k++) begin
         cycle();
         if (ls_fire) begin
            ls_req_we = 1'($urandom_range(0, 1)); ls_req_addr = 4'($urandom_range(0, 11));
            ls_req_wdata = $urandom;
         end
         if (if_fire) if_req_addr = 4'($urandom_range(0, 11));
         if (grant_log.size() >= start + 10) break;
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      idle_cycles(4);
      exp_seq = "LLLLILLLLI";
      for (int i = 0; i < 10; i++) begin
         g = (start + i < grant_log.size()) ? grant_log[start + i] : 8'h3F;
         check_eq($sformatf("starve_grant%0d", i), 32'(g), 32'(exp_seq[i]));
      end

      // Three-cycle memory latency on an IF read.
      lat_mode = 3;
      idle_cycles(2);
      snap_rd = rd_en_cycles;
      if_issue(4'd1);
      idle_cycles(8);
      check_eq("lat3_enable_cycles", 32'(rd_en_cycles - snap_rd), 32'd4);
      check_eq("lat3_resp_latency", 32'(last_if_cyc - last_if_acc), 32'd5);

      // Flush during an IF access suppresses only that response.
      lat_mode = 0;
      idle_cycles(2);
      ls_issue(1'b1, 4'd2, 32'h12345678);
      lat_mode = 2;
      idle_cycles(3);
      snap_if = if_pulses;
      if_issue(4'd2);
      if_flush = 1'b1;
      cycle();
      if_flush = 1'b0;
      idle_cycles(6);
      check_eq("flush_suppressed", 32'(if_pulses - snap_if), 32'd0);
      if_issue(4'd2);
      idle_cycles(6);
      check_eq("post_flush_count", 32'(if_pulses - snap_if), 32'd1);
      check_eq("post_flush_data", last_if_data, 32'h12345678);

      // Out-of-range address goes through the error path.
      ls_issue(1'b0, 4'd14, 32'h0);
      idle_cycles(4);
      check_eq("err_latency", 32'(last_ls_cyc - last_ls_acc), 32'd2);
      check_eq("err_flag", 32'(last_ls_err), 32'd1);
      check_eq("err_data", last_ls_data, 32'd0);

      // Reset in the middle of a slow access abandons it.
      lat_mode = 3;
      idle_cycles(2);
      snap_ls = ls_pulses;
      ls_issue(1'b0, 4'd1, 32'h0);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("rst_mid_enable", 32'({mem_read_enable, mem_write_enable}), 32'd0);
      idle_cycles(8);
      check_eq("rst_mid_no_resp", 32'(ls_pulses - snap_ls), 32'd0);

      // Randomized traffic with random latency, errors and flush pulses.
      lat_mode = -1;
      repeat (400) begin
         if (ls_fire) ls_req_valid = 1'b0;
         if (if_fire) if_req_valid = 1'b0;
         if (!ls_req_valid && $urandom_range(0, 1) == 1) begin
            ls_req_valid = 1'b1; ls_req_we = 1'($urandom_range(0, 1));
            ls_req_addr = 4'($urandom_range(0, 15)); ls_req_wdata = $urandom;
         end
         if (!if_req_valid && $urandom_range(0, 1) == 1) begin
            if_req_valid = 1'b1; if_req_addr = 4'($urandom_range(0, 15));
         end
         if_flush = ($urandom_range(0, 7) == 0);
         cycle();
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0; if_flush = 1'b0;
      idle_cycles(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
